cuckoo_kv_table: RTL and testbench

Two-way cuckoo-hashed key/value store that consumes the key-to-bucket-index mapping of the key-value assignment datapath. It accepts lookup, insert and delete requests on a valid/ready port, resolves collisions by cuckoo eviction between two tables, and holds one overflow entry in a stash. It returns exactly one status response per request. It is the storage and lookup end paired with the hash stage.

---
 rtl/kv_pkg.sv | 32 +++
 rtl/cuckoo_kv_table_if.sv | 21 ++
 rtl/kv_index_pair.sv | 11 +
 rtl/cuckoo_kv_table.sv | 189 ++++++++++++++++++
 tb/tb_cuckoo_kv_table.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kv_pkg.sv
// rtl/kv_pkg.sv - shared types for the cuckoo key/value table
package kv_pkg;
  localparam int KEY_W = 32;
  localparam int VAL_W = 32;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2,
    OP_RSVD   = 2'd3
  } kv_op_e;

  typedef enum logic [2:0] {
    RS_INS_OK   = 3'd0,
    RS_UPDATED  = 3'd1,
    RS_HIT      = 3'd2,
    RS_MISS     = 3'd3,
    RS_DEL_OK   = 3'd4,
    RS_STASHED  = 3'd5,
    RS_FULL     = 3'd6
  } kv_status_e;

  typedef struct packed {
    logic             valid;
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_entry_t;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/cuckoo_kv_table_if.sv
// rtl/cuckoo_kv_table_if.sv - request/response port of the cuckoo key/value table
interface cuckoo_kv_table_if;
  logic                      req_valid;
  logic                      req_ready;
  logic [1:0]                req_op;
  logic [kv_pkg::KEY_W-1:0]  req_key;
  logic [kv_pkg::VAL_W-1:0]  req_val;
  logic                      resp_valid;
  logic [2:0]                resp_status;
  logic [kv_pkg::VAL_W-1:0]  resp_val;

  modport master (
    output req_valid, req_op, req_key, req_val,
    input  req_ready, resp_valid, resp_status, resp_val
  );

  modport slave (
    input  req_valid, req_op, req_key, req_val,
    output req_ready, resp_valid, resp_status, resp_val
  );
endinterface

// File: rtl/kv_index_pair.sv
// rtl/kv_index_pair.sv - the two bucket indices of a key
module kv_index_pair #(
  parameter int IDX_W = 4
) (
  input  logic [3*IDX_W-1:0] key_lo,
  output logic [IDX_W-1:0]   h1,
  output logic [IDX_W-1:0]   h2
);
  assign h1 = key_lo[IDX_W-1:0];
  assign h2 = key_lo[2*IDX_W-1:IDX_W] ^ key_lo[3*IDX_W-1:2*IDX_W];
endmodule

// File: rtl/cuckoo_kv_table.sv
// rtl/cuckoo_kv_table.sv - two-way cuckoo key/value store with a one-entry stash
module cuckoo_kv_table
  import kv_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int MAX_KICKS = 4
) (
  input logic              clk,
  input logic              rst,
  cuckoo_kv_table_if.slave kv
);
  localparam int IDX_W  = idx_width(DEPTH);
  localparam int KICK_W = idx_width(MAX_KICKS + 1);

  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_KICK, S_RESP} state_e;

  state_e            state_q, state_d;
  kv_op_e            op_q, op_d;
  kv_entry_t         req_q, req_d;
  kv_entry_t         carry_q, carry_d;
  logic              side1_q, side1_d;
  logic [KICK_W-1:0] kicks_q, kicks_d;
  kv_status_e        pend_status_q, pend_status_d;
  logic [VAL_W-1:0]  pend_val_q, pend_val_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  kv_status_e        resp_status_q, resp_status_d;
  logic [VAL_W-1:0]  resp_val_q, resp_val_d;
  kv_entry_t         t1_q [DEPTH];
  kv_entry_t         t1_d [DEPTH];
  kv_entry_t         t2_q [DEPTH];
  kv_entry_t         t2_d [DEPTH];
  kv_entry_t         stash_q, stash_d;

  logic [IDX_W-1:0]  rq_h1, rq_h2, ca_h1, ca_h2, kick_idx;
  kv_entry_t         p1, p2, kick_slot;
  logic              hit1, hit2, hit_s;

  kv_index_pair #(.IDX_W(IDX_W)) u_req_idx (
    .key_lo(req_q.key[3*IDX_W-1:0]), .h1(rq_h1), .h2(rq_h2)
  );
  kv_index_pair #(.IDX_W(IDX_W)) u_carry_idx (
    .key_lo(carry_q.key[3*IDX_W-1:0]), .h1(ca_h1), .h2(ca_h2)
  );

  assign p1        = t1_q[rq_h1];
  assign p2        = t2_q[rq_h2];
  assign hit1      = p1.valid && (p1.key == req_q.key);
  assign hit2      = p2.valid && (p2.key == req_q.key);
  assign hit_s     = stash_q.valid && (stash_q.key == req_q.key);
  assign kick_idx  = side1_q ? ca_h1 : ca_h2;
  assign kick_slot = side1_q ? t1_q[kick_idx] : t2_q[kick_idx];

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    req_d         = req_q;
    carry_d       = carry_q;
    side1_d       = side1_q;
    kicks_d       = kicks_q;
    pend_status_d = pend_status_q;
    pend_val_d    = pend_val_q;
    t1_d          = t1_q;
    t2_d          = t2_q;
    stash_d       = stash_q;
    resp_valid_d  = 1'b0;
    resp_status_d = resp_status_q;
    resp_val_d    = resp_val_q;

    case (state_q)
      S_IDLE: begin
        if (kv.req_valid && req_ready_q) begin
          op_d    = kv_op_e'(kv.req_op);
          req_d   = '{valid: 1'b1, key: kv.req_key, val: kv.req_val};
          kicks_d = '0;
          state_d = S_PROBE;
        end
      end
      S_PROBE: begin
        state_d       = S_RESP;
        pend_status_d = RS_MISS;
        pend_val_d    = '0;
        case (op_q)
          OP_LOOKUP: begin
            if (hit1)       begin pend_status_d = RS_HIT; pend_val_d = p1.val; end
            else if (hit2)  begin pend_status_d = RS_HIT; pend_val_d = p2.val; end
            else if (hit_s) begin pend_status_d = RS_HIT; pend_val_d = stash_q.val; end
          end
          OP_DELETE: begin
            if (hit1)       begin t1_d[rq_h1].valid = 1'b0; pend_status_d = RS_DEL_OK; end
            else if (hit2)  begin t2_d[rq_h2].valid = 1'b0; pend_status_d = RS_DEL_OK; end
            else if (hit_s) begin stash_d.valid = 1'b0;     pend_status_d = RS_DEL_OK; end
          end
          OP_INSERT: begin
            if (hit1)       begin t1_d[rq_h1].val = req_q.val; pend_status_d = RS_UPDATED; end
            else if (hit2)  begin t2_d[rq_h2].val = req_q.val; pend_status_d = RS_UPDATED; end
            else if (hit_s) begin stash_d.val = req_q.val;     pend_status_d = RS_UPDATED; end
            else if (stash_q.valid) pend_status_d = RS_FULL;
            else if (!p1.valid) begin t1_d[rq_h1] = req_q; pend_status_d = RS_INS_OK; end
            else if (!p2.valid) begin t2_d[rq_h2] = req_q; pend_status_d = RS_INS_OK; end
            else begin
              carry_d = req_q;
              side1_d = 1'b1;
              kicks_d = '0;
              state_d = S_KICK;
            end
          end
          default: ;
        endcase
      end
      S_KICK: begin
        // An empty slot always wins over the stash, even on the last allowed step.
        if (!kick_slot.valid) begin
          if (side1_q) t1_d[kick_idx] = carry_q;
          else         t2_d[kick_idx] = carry_q;
          pend_status_d = RS_INS_OK;
          pend_val_d    = '0;
          state_d       = S_RESP;
        end else if (kicks_q == KICK_W'(MAX_KICKS)) begin
          stash_d       = carry_q;
          pend_status_d = RS_STASHED;
          pend_val_d    = '0;
          state_d       = S_RESP;
        end else begin
          if (side1_q) t1_d[kick_idx] = carry_q;
          else         t2_d[kick_idx] = carry_q;
          carry_d = kick_slot;
          side1_d = !side1_q;
          kicks_d = kicks_q + 1'b1;
        end
      end
      S_RESP: begin
        resp_valid_d  = 1'b1;
        resp_status_d = pend_status_q;
        resp_val_d    = pend_val_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Ready reopens only once the response pulse has been presented.
    req_ready_d = (state_d == S_IDLE) && (state_q != S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      op_q          <= OP_LOOKUP;
      req_q         <= '0;
      carry_q       <= '0;
      side1_q       <= 1'b1;
      kicks_q       <= '0;
      pend_status_q <= RS_INS_OK;
      pend_val_q    <= '0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_status_q <= RS_INS_OK;
      resp_val_q    <= '0;
      stash_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        t1_q[i] <= '0;
        t2_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      req_q         <= req_d;
      carry_q       <= carry_d;
      side1_q       <= side1_d;
      kicks_q       <= kicks_d;
      pend_status_q <= pend_status_d;
      pend_val_q    <= pend_val_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_status_q <= resp_status_d;
      resp_val_q    <= resp_val_d;
      stash_q       <= stash_d;
      for (int i = 0; i < DEPTH; i++) begin
        t1_q[i] <= t1_d[i];
        t2_q[i] <= t2_d[i];
      end
    end
  end

  assign kv.req_ready   = req_ready_q;
  assign kv.resp_valid  = resp_valid_q;
  assign kv.resp_status = resp_status_q;
  assign kv.resp_val    = resp_val_q;
endmodule

// File: tb/tb_cuckoo_kv_table.sv
// tb/tb_cuckoo_kv_table.sv - bench for cuckoo_kv_table
module tb_cuckoo_kv_table;
  localparam int MAX_KICKS = 4;
  localparam logic [2:0] S_INS_OK = 3'd0, S_UPDATED = 3'd1, S_HIT = 3'd2, S_MISS = 3'd3,
                         S_DEL_OK = 3'd4, S_STASHED = 3'd5, S_FULL = 3'd6;
  localparam logic [1:0] OP_LK = 2'd0, OP_IN = 2'd1, OP_DL = 2'd2, OP_RS = 2'd3;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] key;
    logic [31:0] val;
    logic [2:0]  st;
    logic [31:0] rv;
    logic [3:0]  lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  cuckoo_kv_table_if kv();

  cuckoo_kv_table #(.DEPTH(16), .MAX_KICKS(MAX_KICKS)) dut (
    .clk(clk),
    .rst(rst),
    .kv (kv)
  );

  always #5 clk = ~clk;

  // Reference contents: two 16-entry tables plus a single stash entry.
  bit          m1v [16];
  bit          m2v [16];
  bit          msv;
  logic [31:0] m1k [16];
  logic [31:0] m1d [16];
  logic [31:0] m2k [16];
  logic [31:0] m2d [16];
  logic [31:0] msk, msd;

  function automatic int h1f(input logic [31:0] k);
    return int'(k % 32'd16);
  endfunction

  function automatic int h2f(input logic [31:0] k);
    return int'(((k / 32'd16) ^ (k / 32'd256)) % 32'd16);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m1v[i] = 1'b0;
      m2v[i] = 1'b0;
    end
    msv = 1'b0;
  endtask

  task automatic model_op(input logic [1:0] op, input logic [31:0] k, input logic [31:0] v,
                          output logic [2:0] st, output logic [31:0] rv, output int kc);
    int a, b, idx, kicks;
    bit in1, in2, ins, s1, done;
    logic [31:0] ck, cv, tk, tv;
    a = h1f(k);
    b = h2f(k);
    in1 = m1v[a] && (m1k[a] == k);
    in2 = m2v[b] && (m2k[b] == k);
    ins = msv && (msk == k);
    st = S_MISS;
    rv = 32'h0;
    kc = 0;
    case (op)
      OP_LK: begin
        if (in1)      begin st = S_HIT; rv = m1d[a]; end
        else if (in2) begin st = S_HIT; rv = m2d[b]; end
        else if (ins) begin st = S_HIT; rv = msd; end
      end
      OP_DL: begin
        if (in1)      begin m1v[a] = 1'b0; st = S_DEL_OK; end
        else if (in2) begin m2v[b] = 1'b0; st = S_DEL_OK; end
        else if (ins) begin msv = 1'b0;    st = S_DEL_OK; end
      end
      OP_IN: begin
        if (in1)      begin m1d[a] = v; st = S_UPDATED; end
        else if (in2) begin m2d[b] = v; st = S_UPDATED; end
        else if (ins) begin msd = v;    st = S_UPDATED; end
        else if (msv) st = S_FULL;
        else if (!m1v[a]) begin m1v[a] = 1'b1; m1k[a] = k; m1d[a] = v; st = S_INS_OK; end
        else if (!m2v[b]) begin m2v[b] = 1'b1; m2k[b] = k; m2d[b] = v; st = S_INS_OK; end
        else begin
          ck = k; cv = v; s1 = 1'b1; kicks = 0; done = 1'b0;
          while (!done) begin
            kc++;
            idx = s1 ? h1f(ck) : h2f(ck);
            if (s1 ? !m1v[idx] : !m2v[idx]) begin
              if (s1) begin m1v[idx] = 1'b1; m1k[idx] = ck; m1d[idx] = cv; end
              else    begin m2v[idx] = 1'b1; m2k[idx] = ck; m2d[idx] = cv; end
              st = S_INS_OK;
              done = 1'b1;
            end else if (kicks == MAX_KICKS) begin
              msv = 1'b1; msk = ck; msd = cv;
              st = S_STASHED;
              done = 1'b1;
            end else begin
              if (s1) begin tk = m1k[idx]; tv = m1d[idx]; m1k[idx] = ck; m1d[idx] = cv; end
              else    begin tk = m2k[idx]; tv = m2d[idx]; m2k[idx] = ck; m2d[idx] = cv; end
              ck = tk; cv = tv; s1 = !s1; kicks++;
            end
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic apply_reset();
    kv.req_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // Presents one request, then reports the response and edges from acceptance to the pulse.
  task automatic issue(input logic [1:0] op, input logic [31:0] key, input logic [31:0] v,
                       output logic [2:0] st, output logic [31:0] rv, output int lat, output bit got);
    int guard;
    guard = 0;
    @(negedge clk);
    while (kv.req_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    kv.req_valid = 1'b1;
    kv.req_op    = op;
    kv.req_key   = key;
    kv.req_val   = v;
    @(posedge clk);
    #1 kv.req_valid = 1'b0;
    got = 1'b0; lat = -1; st = 3'bx; rv = 32'bx;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (kv.resp_valid === 1'b1) begin
        got = 1'b1; lat = i; st = kv.resp_status; rv = kv.resp_val;
      end
    end
  endtask

  task automatic test_reset();
    kv.req_valid = 1'b0; kv.req_op = 2'd0; kv.req_key = 32'h0; kv.req_val = 32'h0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({kv.req_ready, kv.resp_valid, kv.resp_status, kv.resp_val} !== {1'b1, 1'b0, 3'd0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_hold ready=%b valid=%b status=%0d val=%0h want 1 0 0 0",
               kv.req_ready, kv.resp_valid, kv.resp_status, kv.resp_val);
    end
    rst = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({kv.req_ready, kv.resp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release ready=%b valid=%b want 1 0", kv.req_ready, kv.resp_valid);
    end
  endtask

  task automatic test_basic();
    vec_t tbl[$];
    logic [2:0] st; logic [31:0] rv; int lat; bit got;
    tbl.push_back(vec_t'{OP_IN, 32'd279, 32'hA, S_INS_OK, 32'h0, 4'd2});
    tbl.push_back(vec_t'{OP_IN, 32'd19,  32'h1, S_INS_OK, 32'h0, 4'd2});
    tbl.push_back(vec_t'{OP_IN, 32'd8,   32'h2, S_INS_OK, 32'h0, 4'd2});
    tbl.push_back(vec_t'{OP_IN, 32'd28,  32'h3, S_INS_OK, 32'h0, 4'd2});
    tbl.push_back(vec_t'{OP_LK, 32'd279, 32'h0, S_HIT,    32'hA, 4'd2});
    tbl.push_back(vec_t'{OP_LK, 32'd23,  32'h0, S_MISS,   32'h0, 4'd2});
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].key, tbl[i].val, st, rv, lat, got);
      n_checks++;
      if (!got || st !== tbl[i].st || rv !== tbl[i].rv || lat != int'(tbl[i].lat)) begin
        n_fail++;
        $display("FAIL basic[%0d] key=%0d got=%b status=%0d want %0d val=%0h want %0h lat=%0d want %0d",
                 i, tbl[i].key, got, st, tbl[i].st, rv, tbl[i].rv, lat, tbl[i].lat);
      end
    end
  endtask

  task automatic test_update_kick();
    vec_t tbl[$];
    logic [2:0] st; logic [31:0] rv; int lat; bit got;
    tbl.push_back(vec_t'{OP_IN, 32'd23,  32'h5, S_INS_OK,  32'h0, 4'd2});
    tbl.push_back(vec_t'{OP_IN, 32'd279, 32'hB, S_UPDATED, 32'h0, 4'd2});
    tbl.push_back(vec_t'{OP_LK, 32'd279, 32'h0, S_HIT,     32'hB, 4'd2});
    tbl.push_back(vec_t'{OP_IN, 32'd263, 32'h7, S_INS_OK,  32'h0, 4'd4});
    tbl.push_back(vec_t'{OP_LK, 32'd279, 32'h0, S_HIT,     32'hB, 4'd2});
    tbl.push_back(vec_t'{OP_LK, 32'd263, 32'h0, S_HIT,     32'h7, 4'd2});
    tbl.push_back(vec_t'{OP_LK, 32'd23,  32'h0, S_HIT,     32'h5, 4'd2});
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].key, tbl[i].val, st, rv, lat, got);
      n_checks++;
      if (!got || st !== tbl[i].st || rv !== tbl[i].rv || lat != int'(tbl[i].lat)) begin
        n_fail++;
        $display("FAIL update_kick[%0d] key=%0d got=%b status=%0d want %0d val=%0h want %0h lat=%0d want %0d",
                 i, tbl[i].key, got, st, tbl[i].st, rv, tbl[i].rv, lat, tbl[i].lat);
      end
    end
  endtask

  task automatic test_delete();
    vec_t tbl[$];
    logic [2:0] st; logic [31:0] rv; int lat; bit got;
    tbl.push_back(vec_t'{OP_DL, 32'd19, 32'h0, S_DEL_OK, 32'h0, 4'd2});
    tbl.push_back(vec_t'{OP_LK, 32'd19, 32'h0, S_MISS,   32'h0, 4'd2});
    tbl.push_back(vec_t'{OP_DL, 32'd19, 32'h0, S_MISS,   32'h0, 4'd2});
    tbl.push_back(vec_t'{OP_RS, 32'd8,  32'h9, S_MISS,   32'h0, 4'd2});
    tbl.push_back(vec_t'{OP_LK, 32'd8,  32'h0, S_HIT,    32'h2, 4'd2});
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].key, tbl[i].val, st, rv, lat, got);
      n_checks++;
      if (!got || st !== tbl[i].st || rv !== tbl[i].rv || lat != int'(tbl[i].lat)) begin
        n_fail++;
        $display("FAIL delete[%0d] key=%0d got=%b status=%0d want %0d val=%0h want %0h lat=%0d want %0d",
                 i, tbl[i].key, got, st, tbl[i].st, rv, tbl[i].rv, lat, tbl[i].lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses, busy_ready, guard;
    logic [2:0] st; logic [31:0] rv;
    pulses = 0; busy_ready = 0; guard = 0; st = 3'bx; rv = 32'bx;
    @(negedge clk);
    while (kv.req_ready !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
    kv.req_valid = 1'b1; kv.req_op = OP_LK; kv.req_key = 32'd28; kv.req_val = 32'h0;
    @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (pulses == 0 && kv.req_ready === 1'b1) busy_ready++;
      if (kv.resp_valid === 1'b1) begin
        pulses++;
        if (pulses == 1) begin st = kv.resp_status; rv = kv.resp_val; kv.req_valid = 1'b0; end
      end
    end
    kv.req_valid = 1'b0;
    n_checks++;
    if (pulses != 1 || busy_ready != 0) begin
      n_fail++;
      $display("FAIL back_to_back pulses=%0d want 1 ready_while_busy=%0d want 0", pulses, busy_ready);
    end
    n_checks++;
    if (st !== S_HIT || rv !== 32'h3) begin
      n_fail++;
      $display("FAIL back_to_back_data status=%0d want %0d val=%0h want 3", st, S_HIT, rv);
    end
  endtask

  task automatic test_stash();
    vec_t tbl[$];
    logic [2:0] st; logic [31:0] rv; int lat; bit got;
    apply_reset();
    tbl.push_back(vec_t'{OP_IN, 32'd23,    32'h1, S_INS_OK,  32'h0, 4'd2});
    tbl.push_back(vec_t'{OP_IN, 32'd263,   32'h2, S_INS_OK,  32'h0, 4'd2});
    tbl.push_back(vec_t'{OP_IN, 32'd567,   32'h3, S_STASHED, 32'h0, 4'd7});
    tbl.push_back(vec_t'{OP_IN, 32'h327,   32'h4, S_FULL,    32'h0, 4'd2});
    tbl.push_back(vec_t'{OP_LK, 32'd23,    32'h0, S_HIT,     32'h1, 4'd2});
    tbl.push_back(vec_t'{OP_LK, 32'd263,   32'h0, S_HIT,     32'h2, 4'd2});
    tbl.push_back(vec_t'{OP_LK, 32'd567,   32'h0, S_HIT,     32'h3, 4'd2});
    tbl.push_back(vec_t'{OP_LK, 32'h327,   32'h0, S_MISS,    32'h0, 4'd2});
    tbl.push_back(vec_t'{OP_DL, 32'd567,   32'h0, S_DEL_OK,  32'h0, 4'd2});
    tbl.push_back(vec_t'{OP_IN, 32'h327,   32'h4, S_FULL,    32'h0, 4'd2});
    tbl.push_back(vec_t'{OP_DL, 32'd23,    32'h0, S_DEL_OK,  32'h0, 4'd2});
    tbl.push_back(vec_t'{OP_IN, 32'h327,   32'h4, S_INS_OK,  32'h0, 4'd2});
    tbl.push_back(vec_t'{OP_LK, 32'h327,   32'h0, S_HIT,     32'h4, 4'd2});
    tbl.push_back(vec_t'{OP_LK, 32'd263,   32'h0, S_HIT,     32'h2, 4'd2});
    tbl.push_back(vec_t'{OP_LK, 32'd23,    32'h0, S_MISS,    32'h0, 4'd2});
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].key, tbl[i].val, st, rv, lat, got);
      n_checks++;
      if (!got || st !== tbl[i].st || rv !== tbl[i].rv || lat != int'(tbl[i].lat)) begin
        n_fail++;
        $display("FAIL stash[%0d] key=%0h got=%b status=%0d want %0d val=%0h want %0h lat=%0d want %0d",
                 i, tbl[i].key, got, st, tbl[i].st, rv, tbl[i].rv, lat, tbl[i].lat);
      end
    end
  endtask

  task automatic test_reset_mid_kick();
    logic [2:0] st; logic [31:0] rv; int lat, pulses, guard; bit got;
    logic [31:0] keys [3];
    keys[0] = 32'd23; keys[1] = 32'd263; keys[2] = 32'd567;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      issue(OP_IN, keys[i], 32'h10 + i, st, rv, lat, got);
      n_checks++;
      if (!got || st !== S_INS_OK) begin
        n_fail++;
        $display("FAIL midkick_setup key=%0d got=%b status=%0d want %0d", keys[i], got, st, S_INS_OK);
      end
    end
    guard = 0;
    @(negedge clk);
    while (kv.req_ready !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
    kv.req_valid = 1'b1; kv.req_op = OP_IN; kv.req_key = keys[2]; kv.req_val = 32'h12;
    @(posedge clk);
    #1 kv.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    pulses = 0;
    repeat (2) @(negedge clk);
    if (kv.resp_valid !== 1'b0) pulses++;
    rst = 1'b0;
    model_clear();
    n_checks++;
    if (kv.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midkick_ready ready=%b want 1", kv.req_ready);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (kv.resp_valid !== 1'b0) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL midkick_no_resp pulses=%0d want 0", pulses);
    end
    for (int i = 0; i < 3; i++) begin
      issue(OP_LK, keys[i], 32'h0, st, rv, lat, got);
      n_checks++;
      if (!got || st !== S_MISS || rv !== 32'h0) begin
        n_fail++;
        $display("FAIL midkick_lookup key=%0d got=%b status=%0d want %0d", keys[i], got, st, S_MISS);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] st, es; logic [31:0] rv, ev, k, v; logic [1:0] op; int lat, kc, r; bit got;
    apply_reset();
    for (int n = 0; n < 120; n++) begin
      k = (32'($urandom_range(0, 2)) << 20) | (32'($urandom_range(0, 1)) << 8) |
          (32'($urandom_range(0, 1)) << 4) | 32'($urandom_range(4, 7));
      v = $urandom;
      r = $urandom_range(0, 9);
      op = (r < 4) ? OP_IN : (r < 7) ? OP_LK : (r < 9) ? OP_DL : OP_RS;
      model_op(op, k, v, es, ev, kc);
      issue(op, k, v, st, rv, lat, got);
      n_checks++;
      if (!got || st !== es || rv !== ev || lat != 2 + kc) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d key=%0h got=%b status=%0d want %0d val=%0h want %0h lat=%0d want %0d",
                 n, op, k, got, st, es, rv, ev, lat, 2 + kc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_update_kick();
    test_delete();
    test_back_to_back();
    test_stash();
    test_reset_mid_kick();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule
